csr_exec_unit: RTL and testbench
================================

CSR_EXEC_UNIT -- requirements
Module: csr_exec_unit

Interface
REQ-001 SHALL have port clk, input, 1: sole clock; all state changes on posedge clk.
REQ-002 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-003 SHALL have port start, input, 1: one-cycle request to execute a CSR instruction; sampled only in IDLE.
REQ-004 SHALL have port funct3, input, 3: instruction funct3 (001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI).
REQ-005 SHALL have port rs1_idx, input, 5: rs1 field; zero-extended as zimm for the immediate forms.
REQ-006 SHALL have port rs1_data, input, 32: rs1 register value.
REQ-007 SHALL have port csr_sel, input, 12: CSR address from the instruction.
REQ-008 SHALL have port csr_readbus, input, 32: combinational read data from the CSR file.
REQ-009 SHALL have port csr_addr, output, 12: address to the CSR file.
REQ-010 SHALL have port data_in, output, 32: write data to the CSR file.
REQ-011 SHALL have port write_en, output, 1: CSR write strobe.
REQ-012 SHALL have port rd_data, output, 32: old CSR value for rd.
REQ-013 SHALL have port rd_valid, output, 1: one-cycle pulse, rd_data valid.
REQ-014 SHALL have port illegal, output, 1: one-cycle pulse, illegal instruction.
REQ-015 SHALL have port busy, output, 1: high in every state except IDLE.

Function
REQ-016 SHALL implement states IDLE, READ, WRITE, DONE, ERR.
REQ-017 IDLE with start=1: latch funct3, rs1_idx, rs1_data, csr_sel; go to ERR if funct3 is 000 or 100, otherwise to READ.
REQ-018 READ SHALL drive csr_addr=latched csr_sel, capture csr_readbus into an old-value register at the cycle end, and go to WRITE.
REQ-019 Operand SHALL be rs1_data for funct3[2]=0 and {27'b0, rs1_idx} for funct3[2]=1.
REQ-020 New value SHALL be operand for RW/RWI, old|operand for RS/RSI, and old&~operand for RC/RCI.
REQ-021 Write suppression: RS/RC/RSI/RCI with rs1_idx=0 SHALL not assert write_en; RW/RWI SHALL always write.
REQ-022 A write to csr_sel[11:10]=2'b11 (read-only) that is not suppressed SHALL go to ERR with no write_en.
REQ-023 Otherwise WRITE SHALL drive csr_addr, data_in=new value, and write_en=1 for exactly one cycle, then go to DONE.
REQ-024 DONE SHALL drive rd_data=old value and rd_valid=1 for one cycle, then go to IDLE.
REQ-025 ERR SHALL drive illegal=1 for one cycle with no rd_valid and no write_en, then go to IDLE.
REQ-026 Latency SHALL be: start at cycle N, write_en at N+2, rd_valid at N+3; the next start is accepted at N+4.
REQ-027 start while busy SHALL be ignored, not queued.
REQ-028 write_en, rd_valid and illegal SHALL never be high in the same cycle.
REQ-029 rd_data SHALL hold its value until the next DONE.
REQ-030 Outside READ and WRITE, csr_addr SHALL hold the last latched csr_sel and data_in SHALL be 0.

Reset
REQ-031 On reset assertion, the state SHALL go to IDLE immediately, including mid-operation, and a pending write SHALL never be issued.
REQ-032 Reset values SHALL be: csr_addr=0, data_in=0, write_en=0, rd_data=0, rd_valid=0, illegal=0, busy=0.

Structure
REQ-033 Package csr_pkg SHALL hold the funct3 encodings, the state enum, and CSR address constants (MSTATUS 0x300, MTVEC 0x305, MISA 0xF10).
REQ-034 New-value and suppression logic SHALL reside in combinational sub-module csr_alu (funct3, operand, old, rs1_idx -> new, wr).

Verification
REQ-035 CSRRW 0x305, rs1_data=0x00012345, old=0x0 -> write_en at N+2, data_in=0x00012345; rd_valid at N+3, rd_data=0x0.
REQ-036 CSRRS 0x300, rs1_idx=5, rs1_data=0x8, old=0x3 -> data_in=0xB; rd_data=0x3.
REQ-037 CSRRC 0x300, rs1_idx=0, old=0xFF -> no write_en; rd_valid with rd_data=0xFF.
REQ-038 CSRRWI 0xF10, zimm=1 -> illegal pulse at N+2, no write_en, no rd_valid; CSRRS 0xF10, rs1_idx=0 -> legal read, rd_data=0x80100100.
REQ-039 funct3=100 -> illegal at N+1; start pulsed at N+1 during a legal op -> ignored, exactly one write_en.
REQ-040 Reset asserted at N+1 of a CSRRW -> no write_en ever; all outputs 0; a new start after reset release completes normally.

Source files
------------

// File: rtl/csr_pkg.sv
// Shared encodings for the CSR execution unit: funct3 opcodes, FSM states and
// well-known CSR addresses.
package csr_pkg;

  localparam logic [2:0] Funct3Rw  = 3'b001;
  localparam logic [2:0] Funct3Rs  = 3'b010;
  localparam logic [2:0] Funct3Rc  = 3'b011;
  localparam logic [2:0] Funct3Rwi = 3'b101;
  localparam logic [2:0] Funct3Rsi = 3'b110;
  localparam logic [2:0] Funct3Rci = 3'b111;

  localparam logic [11:0] CsrMstatus = 12'h300;
  localparam logic [11:0] CsrMtvec   = 12'h305;
  localparam logic [11:0] CsrMisa    = 12'hF10;

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StWrite,
    StDone,
    StErr
  } csr_state_e;

  // 000 and 100 are the only funct3 values in the SYSTEM space that are not CSR ops.
  function automatic logic funct3_legal(logic [2:0] funct3);
    return funct3[1:0] != 2'b00;
  endfunction

  function automatic logic is_read_only(logic [11:0] addr);
    return addr[11:10] == 2'b11;
  endfunction

endpackage

// File: rtl/csr_exec_unit_if.sv
// Request/CSR-file bus of the CSR execution unit. The slave modport is the
// unit itself; the master side is the pipeline plus the CSR file.
interface csr_exec_unit_if;
  logic        start;
  logic [2:0]  funct3;
  logic [4:0]  rs1_idx;
  logic [31:0] rs1_data;
  logic [11:0] csr_sel;
  logic [31:0] csr_readbus;
  logic [11:0] csr_addr;
  logic [31:0] data_in;
  logic        write_en;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        illegal;
  logic        busy;

  modport slave (
    input  start, funct3, rs1_idx, rs1_data, csr_sel, csr_readbus,
    output csr_addr, data_in, write_en, rd_data, rd_valid, illegal, busy
  );

  modport master (
    output start, funct3, rs1_idx, rs1_data, csr_sel, csr_readbus,
    input  csr_addr, data_in, write_en, rd_data, rd_valid, illegal, busy
  );
endinterface

// File: rtl/csr_alu.sv
// Combinational new-value computation and write-suppression decision for the
// RW/RS/RC families (register and immediate forms).
module csr_alu
  import csr_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] operand,
  input  logic [31:0] old,
  input  logic [4:0]  rs1_idx,
  output logic [31:0] new_value,
  output logic        wr
);

  always_comb begin
    new_value = operand;
    unique case (funct3)
      Funct3Rw, Funct3Rwi: new_value = operand;
      Funct3Rs, Funct3Rsi: new_value = old | operand;
      Funct3Rc, Funct3Rci: new_value = old & ~operand;
      default:             new_value = operand;
    endcase
  end

  // Set/clear with x0 or zimm=0 is a pure read and must not touch the CSR.
  assign wr = (funct3 == Funct3Rw) || (funct3 == Funct3Rwi) || (rs1_idx != 5'd0);

endmodule

// File: rtl/csr_exec_unit.sv
// Multi-cycle CSR instruction executor: read old value, optionally write the
// new one, then return the old value for rd or flag an illegal instruction.
module csr_exec_unit
  import csr_pkg::*;
(
  input logic      clk,
  input logic      reset,
  csr_exec_unit_if.slave bus
);

  csr_state_e  state_q, state_d;
  logic [2:0]  funct3_q;
  logic [4:0]  idx_q;
  logic [31:0] data_q;
  logic [11:0] sel_q;
  logic [31:0] old_q;
  logic [31:0] rd_q;
  logic [31:0] operand;
  logic [31:0] new_value;
  logic        alu_wr;

  assign operand = funct3_q[2] ? {27'b0, idx_q} : data_q;

  csr_alu u_alu (
    .funct3    (funct3_q),
    .operand   (operand),
    .old       (old_q),
    .rs1_idx   (idx_q),
    .new_value (new_value),
    .wr        (alu_wr)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      funct3_q <= 3'b0;
      idx_q    <= 5'b0;
      data_q   <= 32'b0;
      sel_q    <= 12'b0;
      old_q    <= 32'b0;
      rd_q     <= 32'b0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && bus.start) begin
        funct3_q <= bus.funct3;
        idx_q    <= bus.rs1_idx;
        data_q   <= bus.rs1_data;
        sel_q    <= bus.csr_sel;
      end
      if (state_q == StRead) old_q <= bus.csr_readbus;
      // rd_q is a separate register so rd_data holds until the next DONE.
      if (state_q == StWrite) rd_q <= old_q;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) state_d = funct3_legal(bus.funct3) ? StRead : StErr;
      end
      StRead:  state_d = (alu_wr && is_read_only(sel_q)) ? StErr : StWrite;
      StWrite: state_d = StDone;
      StDone:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign bus.csr_addr = sel_q;
  assign bus.data_in  = (state_q == StWrite) ? new_value : 32'b0;
  assign bus.write_en = (state_q == StWrite) && alu_wr;
  assign bus.rd_data  = rd_q;
  assign bus.rd_valid = (state_q == StDone);
  assign bus.illegal  = (state_q == StErr);
  assign bus.busy     = (state_q != StIdle);

endmodule

// File: tb/tb_csr_exec_unit.sv
// Directed bench for csr_exec_unit: a cycle-level outcome model compared every
// cycle, plus per-instruction literal expectations.
module tb_csr_exec_unit;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  csr_exec_unit_if bus ();

  csr_exec_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] csr_mem   [4096];
  logic [31:0] model_mem [4096];
  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  assign bus.csr_readbus = csr_mem[bus.csr_addr];
  always @(posedge clk) if (bus.write_en) csr_mem[bus.csr_addr] <= bus.data_in;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%08h, want 0x%08h", name, cyc, act, exp);
    end
  endtask

  // Outcome model: when an instruction is accepted, its whole future is scheduled.
  int          accept_c = 0;
  int          we_c = -1, rv_c = -1, ill_c = -1;
  logic [31:0] we_val = 0, rv_val = 0;
  logic [11:0] m_addr = 0;
  logic [31:0] m_rd = 0;

  always @(negedge clk) begin : model
    logic [31:0] op, old, nv;
    logic wr;
    int c;
    c = cyc;
    if (reset) begin
      accept_c = c;
      we_c = -1; rv_c = -1; ill_c = -1;
      m_addr = 0; m_rd = 0;
      check32("rst_busy", {31'b0, bus.busy}, 0);
      check32("rst_we", {31'b0, bus.write_en}, 0);
      check32("rst_rv", {31'b0, bus.rd_valid}, 0);
      check32("rst_ill", {31'b0, bus.illegal}, 0);
      check32("rst_addr", {20'b0, bus.csr_addr}, 0);
      check32("rst_din", bus.data_in, 0);
      check32("rst_rd", bus.rd_data, 0);
    end else begin
      if (c == rv_c) m_rd = rv_val;
      check32("m_busy", {31'b0, bus.busy}, {31'b0, c < accept_c});
      check32("m_we", {31'b0, bus.write_en}, {31'b0, c == we_c});
      check32("m_rv", {31'b0, bus.rd_valid}, {31'b0, c == rv_c});
      check32("m_ill", {31'b0, bus.illegal}, {31'b0, c == ill_c});
      check32("m_addr", {20'b0, bus.csr_addr}, {20'b0, m_addr});
      check32("m_rd", bus.rd_data, m_rd);
      if (c == we_c) begin
        check32("m_din", bus.data_in, we_val);
        model_mem[m_addr] = we_val;
      end
      if (c >= accept_c) check32("m_din_idle", bus.data_in, 0);
      if (bus.start && c >= accept_c) begin
        we_c = -1; rv_c = -1; ill_c = -1;
        m_addr = bus.csr_sel;
        if (bus.funct3[1:0] == 2'b00) begin
          ill_c = c + 1;
          accept_c = c + 2;
        end else begin
          op  = bus.funct3[2] ? {27'b0, bus.rs1_idx} : bus.rs1_data;
          old = model_mem[bus.csr_sel];
          case (bus.funct3[1:0])
            2'b01:   nv = op;
            2'b10:   nv = old | op;
            default: nv = old & ~op;
          endcase
          wr = (bus.funct3[1:0] == 2'b01) || (bus.rs1_idx != 0);
          if (wr && bus.csr_sel[11:10] == 2'b11) begin
            ill_c = c + 2;
            accept_c = c + 3;
          end else begin
            if (wr) begin
              we_c = c + 2;
              we_val = nv;
            end
            rv_c = c + 3;
            rv_val = old;
            accept_c = c + 4;
          end
        end
      end
    end
  end

  // Issue one instruction and record at which offset from N each pulse appears.
  task automatic run_op(input string name, input logic [2:0] f3, input logic [4:0] idx,
                        input logic [31:0] data, input logic [11:0] sel,
                        input int e_we_at, input logic [31:0] e_wd,
                        input int e_rv_at, input logic [31:0] e_rd, input int e_ill_at);
    int we_at, rv_at, ill_at;
    logic [31:0] wd, rdv;
    we_at = -1; rv_at = -1; ill_at = -1; wd = 0; rdv = 0;
    @(posedge clk); #1;
    bus.funct3 = f3; bus.rs1_idx = idx; bus.rs1_data = data; bus.csr_sel = sel;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (bus.write_en) begin we_at = k; wd = bus.data_in; end
      if (bus.rd_valid) begin rv_at = k; rdv = bus.rd_data; end
      if (bus.illegal) ill_at = k;
    end
    check32({name, "_we_at"}, we_at, e_we_at);
    if (e_we_at >= 0) check32({name, "_wdata"}, wd, e_wd);
    check32({name, "_rv_at"}, rv_at, e_rv_at);
    if (e_rv_at >= 0) check32({name, "_rd"}, rdv, e_rd);
    check32({name, "_ill_at"}, ill_at, e_ill_at);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1);
  end

  initial begin : main
    int cnt;
    for (int i = 0; i < 4096; i++) begin
      csr_mem[i] = 32'h0;
      model_mem[i] = 32'h0;
    end
    csr_mem[12'h300] = 32'h3;          model_mem[12'h300] = 32'h3;
    csr_mem[12'hF10] = 32'h8010_0100;  model_mem[12'hF10] = 32'h8010_0100;
    bus.start = 0; bus.funct3 = 0; bus.rs1_idx = 0; bus.rs1_data = 0; bus.csr_sel = 0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check32("reset_busy", {31'b0, bus.busy}, 0);
    check32("reset_rd", bus.rd_data, 0);
    @(posedge clk); #1 reset = 1'b0;

    run_op("csrrw_mtvec",  3'b001, 5'd0,  32'h0001_2345, 12'h305, 2, 32'h0001_2345, 3, 32'h0, -1);
    run_op("csrrs_mstat",  3'b010, 5'd5,  32'h8,         12'h300, 2, 32'hB,         3, 32'h3, -1);
    run_op("csrrw_mstat",  3'b001, 5'd1,  32'hFF,        12'h300, 2, 32'hFF,        3, 32'hB, -1);
    run_op("csrrc_x0",     3'b011, 5'd0,  32'hFFFF,      12'h300, -1, 32'h0,        3, 32'hFF, -1);
    run_op("csrrwi_misa",  3'b101, 5'd1,  32'h0,         12'hF10, -1, 32'h0,        -1, 32'h0, 2);
    run_op("csrrs_misa",   3'b010, 5'd0,  32'h0,         12'hF10, -1, 32'h0,        3, 32'h8010_0100, -1);
    run_op("f3_100",       3'b100, 5'd1,  32'h1,         12'h300, -1, 32'h0,        -1, 32'h0, 1);
    run_op("csrrci",       3'b111, 5'd15, 32'hFFFF_FFFF, 12'h300, 2, 32'hF0,        3, 32'hFF, -1);
    run_op("csrrsi",       3'b110, 5'd18, 32'h0,         12'h300, 2, 32'hF2,        3, 32'hF0, -1);
    run_op("csrrc_reg",    3'b011, 5'd3,  32'hF0,        12'h300, 2, 32'h02,        3, 32'hF2, -1);
    run_op("f3_000",       3'b000, 5'd0,  32'h0,         12'h305, -1, 32'h0,        -1, 32'h0, 1);

    // A second start one cycle into a legal op must be dropped, not queued.
    @(posedge clk); #1;
    bus.funct3 = 3'b001; bus.rs1_idx = 5'd2; bus.rs1_data = 32'hAAAA; bus.csr_sel = 12'h305;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.rs1_data = 32'h5555; bus.csr_sel = 12'h300;
    @(posedge clk); #1;
    bus.start = 1'b0;
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.write_en) begin
        cnt++;
        check32("ignored_wdata", bus.data_in, 32'hAAAA);
      end
    end
    check32("ignored_we_count", cnt, 1);

    // Reset one cycle into a CSRRW: the write must never reach the CSR file.
    @(posedge clk); #1;
    bus.funct3 = 3'b001; bus.rs1_idx = 5'd1; bus.rs1_data = 32'h1111; bus.csr_sel = 12'h305;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    reset = 1'b1;
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.write_en) cnt++;
    end
    check32("rst_mid_addr", {20'b0, bus.csr_addr}, 0);
    @(posedge clk); #1 reset = 1'b0;
    check32("rst_mid_we_count", cnt, 0);
    check32("rst_mid_mem", csr_mem[12'h305], 32'hAAAA);

    run_op("after_reset",  3'b001, 5'd1,  32'h2222,      12'h305, 2, 32'h2222,      3, 32'hAAAA, -1);
    check32("final_mtvec", csr_mem[12'h305], 32'h2222);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
